// File: rtl/systolic_mm_param_if.sv
// Bus bundle for the parameterised systolic matrix multiplier: operand
// matrices, per-request mode bits, start/busy/done handshake and result matrix.
`timescale 1ns/1ps

interface systolic_mm_param_if #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int AW = 20
);
    logic                  start_i;
    logic                  signed_i;
    logic                  acc_i;
    logic [N*N*DW-1:0]     a_i;
    logic [N*N*DW-1:0]     b_i;
    logic [N*N*AW-1:0]     c_o;
    logic                  busy_o;
    logic                  done_o;

    // Requester side: issues operands and start, observes result and status.
    modport master (
        output start_i, signed_i, acc_i, a_i, b_i,
        input  c_o, busy_o, done_o
    );

    // Multiplier side.
    modport slave (
        input  start_i, signed_i, acc_i, a_i, b_i,
        output c_o, busy_o, done_o
    );
endinterface

// File: rtl/systolic_mm_param.sv
// Output-stationary N x N systolic matrix multiplier. One request computes
// C = A*B (or C += A*B) in 3N cycles: LOAD, 3N-2 RUN cycles, DONE.
// A enters on the left edge skewed by row, B enters on the top edge skewed
// by column; every PE multiplies what reaches it and keeps its own sum.
`timescale 1ns/1ps

module systolic_mm_param #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int AW = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    systolic_mm_param_if.slave    bus
);

    localparam int NN   = N * N;
    localparam int LAST = 3 * N - 3;       // index of the final RUN cycle
    localparam int CW   = $clog2(3 * N);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NN*DW-1:0]   a_mat_q, a_mat_d;
    logic [NN*DW-1:0]   b_mat_q, b_mat_d;
    logic               signed_q, signed_d;
    logic               acc_mode_q, acc_mode_d;
    logic [NN*AW-1:0]   c_q, c_d;

    // Edge injection values and inter-PE operand links.
    logic [DW-1:0]      skew_a [N];
    logic [DW-1:0]      skew_b [N];
    logic [DW-1:0]      a_pipe_w [NN];
    logic [DW-1:0]      b_pipe_w [NN];
    logic [AW-1:0]      acc_next_w [NN];

    // Control FSM: next state, operand capture, cycle counter, result capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_mat_d    = a_mat_q;
        b_mat_d    = b_mat_q;
        signed_d   = signed_q;
        acc_mode_d = acc_mode_q;
        c_d        = c_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d    = LOAD;
                    a_mat_d    = bus.a_i;
                    b_mat_d    = bus.b_i;
                    signed_d   = bus.signed_i;
                    acc_mode_d = bus.acc_i;
                end
            end
            LOAD: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(LAST)) begin
                    // Last MAC lands this edge, so capture the next-sum values.
                    state_d = DONE;
                    for (int i = 0; i < NN; i++) begin
                        c_d[i*AW +: AW] = acc_next_w[i];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_mat_q    <= '0;
            b_mat_q    <= '0;
            signed_q   <= 1'b0;
            acc_mode_q <= 1'b0;
            c_q        <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_mat_q    <= a_mat_d;
            b_mat_q    <= b_mat_d;
            signed_q   <= signed_d;
            acc_mode_q <= acc_mode_d;
            c_q        <= c_d;
        end
    end

    // Skewed edge feed: row r gets A(r, k-r) and column c gets B(k-c, c) at RUN cycle k.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            skew_a[r] = '0;
            skew_b[r] = '0;
            if (state_q == RUN) begin
                if (int'(cnt_q) >= r && int'(cnt_q) < r + N) begin
                    skew_a[r] = a_mat_q[(r*N + int'(cnt_q) - r)*DW +: DW];
                    skew_b[r] = b_mat_q[((int'(cnt_q) - r)*N + r)*DW +: DW];
                end
            end
        end
    end

    assign bus.busy_o = (state_q != IDLE);
    assign bus.done_o = (state_q == DONE);
    assign bus.c_o    = c_q;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                localparam int IDX = gi * N + gj;

                logic [DW-1:0]          a_in, b_in;
                logic [DW-1:0]          a_reg_q, a_reg_d;
                logic [DW-1:0]          b_reg_q, b_reg_d;
                logic [AW-1:0]          sum_q, sum_d;
                logic signed [DW:0]     a_ext, b_ext;
                logic signed [2*DW+1:0] prod;
                logic [AW-1:0]          prod_ext;

                if (gj == 0) begin : g_a_edge
                    assign a_in = skew_a[gi];
                end else begin : g_a_link
                    assign a_in = a_pipe_w[IDX-1];
                end

                if (gi == 0) begin : g_b_edge
                    assign b_in = skew_b[gj];
                end else begin : g_b_link
                    assign b_in = b_pipe_w[IDX-N];
                end

                // One MAC per RUN cycle; LOAD clears or preloads with the old result.
                always_comb begin
                    a_ext    = {signed_q & a_in[DW-1], a_in};
                    b_ext    = {signed_q & b_in[DW-1], b_in};
                    prod     = a_ext * b_ext;
                    prod_ext = AW'(prod);
                    a_reg_d  = a_reg_q;
                    b_reg_d  = b_reg_q;
                    sum_d    = sum_q;
                    if (state_q == LOAD) begin
                        a_reg_d = '0;
                        b_reg_d = '0;
                        sum_d   = acc_mode_q ? c_q[IDX*AW +: AW] : '0;
                    end else if (state_q == RUN) begin
                        a_reg_d = a_in;
                        b_reg_d = b_in;
                        sum_d   = sum_q + prod_ext;
                    end
                end

                // PE operand and accumulator registers.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_reg_q <= '0;
                        b_reg_q <= '0;
                        sum_q   <= '0;
                    end else begin
                        a_reg_q <= a_reg_d;
                        b_reg_q <= b_reg_d;
                        sum_q   <= sum_d;
                    end
                end

                assign a_pipe_w[IDX]   = a_reg_q;
                assign b_pipe_w[IDX]   = b_reg_q;
                assign acc_next_w[IDX] = sum_d;
            end
        end
    endgenerate

endmodule

// File: tb/tb_systolic_mm_param.sv
// Directed bench for systolic_mm_param: three instances (N=3 unsigned,
// N=2 signed, N=2 with 16-bit wrap), one task per scenario.
`timescale 1ns/1ps

module tb_systolic_mm_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_mm_param_if #(.N(3), .DW(8), .AW(20)) if3  ();
    systolic_mm_param_if #(.N(2), .DW(8), .AW(20)) if2s ();
    systolic_mm_param_if #(.N(2), .DW(8), .AW(16)) if2w ();

    systolic_mm_param #(.N(3), .DW(8), .AW(20)) dut3  (.clk(clk), .rst(rst), .bus(if3));
    systolic_mm_param #(.N(2), .DW(8), .AW(20)) dut2s (.clk(clk), .rst(rst), .bus(if2s));
    systolic_mm_param #(.N(2), .DW(8), .AW(16)) dut2w (.clk(clk), .rst(rst), .bus(if2w));

    int tests_run    = 0;
    int tests_failed = 0;

    int exp_ab  [9] = '{84, 90, 96, 201, 216, 231, 318, 342, 366};
    int exp_acc [9] = '{168, 180, 192, 402, 432, 462, 636, 684, 732};

    logic [71:0] mat_a, mat_b, mat_alt, mat_id;

    // Drive one request on the N=3 instance; returns in cycle 1 (LOAD).
    task automatic start3(input logic [71:0] a, input logic [71:0] b,
                          input logic sgn, input logic acc);
        if3.a_i      = a;
        if3.b_i      = b;
        if3.signed_i = sgn;
        if3.acc_i    = acc;
        if3.start_i  = 1'b1;
        @(posedge clk); #1;
        if3.start_i  = 1'b0;
    endtask

    // Advance until done_o, counting cycles after the accept edge (bounded).
    task automatic wait_done3(input int from, output int lat);
        lat = from;
        while (!if3.done_o && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (if3.c_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_c: got %h expected 0", if3.c_o);
        end
        tests_run++;
        if (if3.busy_o !== 1'b0 || if3.done_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: busy=%b done=%b expected 0 0", if3.busy_o, if3.done_o);
        end
        tests_run++;
        if (if2s.c_o !== '0 || if2s.busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_n2: c=%h busy=%b expected 0 0", if2s.c_o, if2s.busy_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("[TB] reset checked");
    endtask

    task automatic test_unsigned();
        int lat;
        start3(mat_a, mat_b, 1'b0, 1'b0);
        tests_run++;
        if (if3.busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL unsigned_busy: got %b expected 1", if3.busy_o);
        end
        wait_done3(1, lat);
        tests_run++;
        if (lat != 9) begin
            tests_failed++;
            $display("FAIL unsigned_latency: got %0d expected 9", lat);
        end
        for (int i = 0; i < 9; i++) begin
            tests_run++;
            if (if3.c_o[i*20 +: 20] !== 20'(exp_ab[i])) begin
                tests_failed++;
                $display("FAIL unsigned_c%0d: got %0d expected %0d", i, if3.c_o[i*20 +: 20], exp_ab[i]);
            end
        end
        @(posedge clk); #1;
        tests_run++;
        if (if3.done_o !== 1'b0 || if3.busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL unsigned_pulse: done=%b busy=%b expected 0 0", if3.done_o, if3.busy_o);
        end
        $display("[TB] unsigned product: latency %0d", lat);
    endtask

    task automatic test_accumulate();
        int lat;
        start3(mat_a, mat_b, 1'b0, 1'b1);
        if3.acc_i = 1'b0;
        wait_done3(1, lat);
        tests_run++;
        if (lat != 9) begin
            tests_failed++;
            $display("FAIL acc_latency: got %0d expected 9", lat);
        end
        for (int i = 0; i < 9; i++) begin
            tests_run++;
            if (if3.c_o[i*20 +: 20] !== 20'(exp_acc[i])) begin
                tests_failed++;
                $display("FAIL acc_c%0d: got %0d expected %0d", i, if3.c_o[i*20 +: 20], exp_acc[i]);
            end
        end
        @(posedge clk); #1;
        $display("[TB] accumulate product: latency %0d", lat);
    endtask

    task automatic test_start_while_busy();
        int lat;
        bit extra_done;
        start3(mat_a, mat_b, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end      // cycle 4 = RUN cycle 2
        if3.a_i      = mat_alt;
        if3.b_i      = mat_id;
        if3.signed_i = 1'b1;
        if3.acc_i    = 1'b1;
        if3.start_i  = 1'b1;
        @(posedge clk); #1;
        if3.start_i  = 1'b0;
        wait_done3(5, lat);
        tests_run++;
        if (lat != 9) begin
            tests_failed++;
            $display("FAIL busy_start_latency: got %0d expected 9", lat);
        end
        for (int i = 0; i < 9; i++) begin
            tests_run++;
            if (if3.c_o[i*20 +: 20] !== 20'(exp_ab[i])) begin
                tests_failed++;
                $display("FAIL busy_start_c%0d: got %0d expected %0d", i, if3.c_o[i*20 +: 20], exp_ab[i]);
            end
        end
        extra_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if3.done_o || if3.busy_o) extra_done = 1'b1;
        end
        tests_run++;
        if (extra_done) begin
            tests_failed++;
            $display("FAIL busy_start_queued: got activity=1 expected 0");
        end
        if3.a_i = mat_a; if3.b_i = mat_b; if3.signed_i = 1'b0; if3.acc_i = 1'b0;
        $display("[TB] start while busy ignored: latency %0d", lat);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit saw_done;
        start3(mat_a, mat_b, 1'b0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end      // cycle 5 = RUN cycle 3
        rst = 1'b1;
        #1;
        tests_run++;
        if (if3.c_o !== '0 || if3.done_o !== 1'b0 || if3.busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_reset: c=%h done=%b busy=%b expected 0 0 0", if3.c_o, if3.done_o, if3.busy_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if3.done_o) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done) begin
            tests_failed++;
            $display("FAIL midrun_done: got done=1 expected 0");
        end
        start3(mat_a, mat_b, 1'b0, 1'b0);
        wait_done3(1, lat);
        tests_run++;
        if (lat != 9) begin
            tests_failed++;
            $display("FAIL midrun_rerun_latency: got %0d expected 9", lat);
        end
        for (int i = 0; i < 9; i++) begin
            tests_run++;
            if (if3.c_o[i*20 +: 20] !== 20'(exp_ab[i])) begin
                tests_failed++;
                $display("FAIL midrun_rerun_c%0d: got %0d expected %0d", i, if3.c_o[i*20 +: 20], exp_ab[i]);
            end
        end
        @(posedge clk); #1;
        $display("[TB] reset mid-run and rerun: latency %0d", lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        if3.a_i = mat_a; if3.b_i = mat_b; if3.signed_i = 1'b0; if3.acc_i = 1'b0;
        if3.start_i = 1'b1;
        @(posedge clk); #1;                           // cycle 1
        if3.b_i = mat_id;                             // picked up by the second request only
        wait_done3(1, lat);
        tests_run++;
        if (lat != 9) begin
            tests_failed++;
            $display("FAIL b2b_first_latency: got %0d expected 9", lat);
        end
        tests_run++;
        if (if3.c_o[8*20 +: 20] !== 20'd366 || if3.c_o[0 +: 20] !== 20'd84) begin
            tests_failed++;
            $display("FAIL b2b_first_c: got c0=%0d c8=%0d expected 84 366", if3.c_o[0 +: 20], if3.c_o[8*20 +: 20]);
        end
        @(posedge clk); #1;                           // cycle 10: IDLE
        tests_run++;
        if (if3.busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: busy got %b expected 0", if3.busy_o);
        end
        @(posedge clk); #1;                           // cycle 11: LOAD of second request
        if3.start_i = 1'b0;
        tests_run++;
        if (if3.busy_o !== 1'b1 || if3.c_o[4*20 +: 20] !== 20'd216) begin
            tests_failed++;
            $display("FAIL b2b_restart: busy=%b c4=%0d expected 1 216", if3.busy_o, if3.c_o[4*20 +: 20]);
        end
        wait_done3(11, lat);
        tests_run++;
        if (lat != 19) begin
            tests_failed++;
            $display("FAIL b2b_second_latency: got %0d expected 19", lat);
        end
        for (int i = 0; i < 9; i++) begin
            tests_run++;
            if (if3.c_o[i*20 +: 20] !== 20'(i + 1)) begin
                tests_failed++;
                $display("FAIL b2b_second_c%0d: got %0d expected %0d", i, if3.c_o[i*20 +: 20], i + 1);
            end
        end
        @(posedge clk); #1;
        $display("[TB] back-to-back: second done at cycle %0d", lat);
    endtask

    task automatic test_signed();
        int lat;
        logic [19:0] exp_s [4];
        exp_s[0] = 20'd9; exp_s[1] = 20'd10; exp_s[2] = 20'hFFFF3; exp_s[3] = 20'hFFFF2;
        if2s.a_i      = {8'hFC, 8'd3, 8'd2, 8'hFF};   // [-1,2;3,-4]
        if2s.b_i      = {8'd8, 8'd7, 8'd6, 8'd5};
        if2s.signed_i = 1'b1;
        if2s.acc_i    = 1'b0;
        if2s.start_i  = 1'b1;
        @(posedge clk); #1;
        if2s.start_i  = 1'b0;
        lat = 1;
        while (!if2s.done_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        tests_run++;
        if (lat != 6) begin
            tests_failed++;
            $display("FAIL signed_latency: got %0d expected 6", lat);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (if2s.c_o[i*20 +: 20] !== exp_s[i]) begin
                tests_failed++;
                $display("FAIL signed_c%0d: got %h expected %h", i, if2s.c_o[i*20 +: 20], exp_s[i]);
            end
        end
        @(posedge clk); #1;
        $display("[TB] signed product: latency %0d", lat);
    endtask

    task automatic test_wrap();
        int lat;
        if2w.a_i      = {4{8'hFF}};
        if2w.b_i      = {4{8'hFF}};
        if2w.signed_i = 1'b0;
        if2w.acc_i    = 1'b0;
        if2w.start_i  = 1'b1;
        @(posedge clk); #1;
        if2w.start_i  = 1'b0;
        lat = 1;
        while (!if2w.done_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        tests_run++;
        if (lat != 6) begin
            tests_failed++;
            $display("FAIL wrap_latency: got %0d expected 6", lat);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (if2w.c_o[i*16 +: 16] !== 16'd64514) begin
                tests_failed++;
                $display("FAIL wrap_c%0d: got %0d expected 64514", i, if2w.c_o[i*16 +: 16]);
            end
        end
        @(posedge clk); #1;
        $display("[TB] wrap product: latency %0d", lat);
    endtask

    initial begin
        rst = 1'b1;
        if3.start_i = 1'b0;  if3.signed_i = 1'b0;  if3.acc_i = 1'b0;  if3.a_i = '0;  if3.b_i = '0;
        if2s.start_i = 1'b0; if2s.signed_i = 1'b0; if2s.acc_i = 1'b0; if2s.a_i = '0; if2s.b_i = '0;
        if2w.start_i = 1'b0; if2w.signed_i = 1'b0; if2w.acc_i = 1'b0; if2w.a_i = '0; if2w.b_i = '0;
        mat_id = '0;
        for (int i = 0; i < 9; i++) begin
            mat_a[i*8 +: 8]   = 8'(i + 1);
            mat_b[i*8 +: 8]   = 8'(i + 10);
            mat_alt[i*8 +: 8] = 8'(200 - i * 7);
        end
        for (int i = 0; i < 3; i++) mat_id[(i*3 + i)*8 +: 8] = 8'd1;

        test_reset();
        test_unsigned();
        test_accumulate();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_signed();
        test_wrap();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
